// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned PEND_W_DEF = 2;

    // At least one address bit, even for a two-entry file.
    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int unsigned AW_DEF   = addr_width(NREGS_DEF);
    localparam int unsigned ZERO_REG = 0;
    localparam int unsigned PEND_MAX = (2 ** PEND_W_DEF) - 1;

    typedef logic [AW_DEF-1:0]     reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   xlen_t;
    typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down pending-write counter with synchronous clear and zero/full flags.
module pend_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         full_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero_o = ~|cnt_q;
    assign full_o = &cnt_q;
    assign cnt_o  = cnt_q;

    // Simultaneous inc and dec cancel; ends never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters for RAW / overflow stalls.
// Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned PEND_W = 2,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_dest_i,
    output logic                iss_ready_o,
    input  logic                wb_valid_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [XLEN-1:0]     wb_data_i,
    input  logic                flush_i,
    output logic                pend_any_o
);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [PEND_W-1:0] cnt_w  [NREGS];
    logic [NREGS-1:0]  zero_w;
    logic [NREGS-1:0]  full_w;
    logic [NREGS-1:1]  inc_w;
    logic [NREGS-1:1]  dec_w;
    logic              wb_en;

    assign wb_en = wb_valid_i && (wb_addr_i != AW'(ZERO_REG));

    assign iss_ready_o = (iss_dest_i == AW'(ZERO_REG)) || !full_w[iss_dest_i];
    assign pend_any_o  = ~&zero_w;

    // r0 has no counter: permanently idle.
    assign cnt_w[0]  = '0;
    assign zero_w[0] = 1'b1;
    assign full_w[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        assign inc_w[r] = iss_valid_i && iss_ready_o && (iss_dest_i == AW'(r));
        assign dec_w[r] = wb_en && (wb_addr_i == AW'(r));

        pend_counter #(
            .W (PEND_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (inc_w[r]),
            .dec_i  (dec_w[r]),
            .clr_i  (flush_i),
            .cnt_o  (cnt_w[r]),
            .zero_o (zero_w[r]),
            .full_o (full_w[r])
        );
    end

    // Entry 0 is never written and stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          nz;
        logic          pend;

        assign addr = rd_addr_i[i*AW +: AW];
        assign nz   = (addr != AW'(ZERO_REG));
        assign pend = nz && (cnt_w[addr] != '0);

`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = wb_en && (wb_addr_i == addr);

        assign rd_data_o[i*XLEN +: XLEN] = hit ? wb_data_i : (nz ? regs_q[addr] : '0);
        // This writeback resolves the last outstanding write only when cnt is exactly 1.
        assign rd_busy_o[i] = pend && !(hit && (cnt_w[addr] == PEND_W'(1)));
`else
        assign rd_data_o[i*XLEN +: XLEN] = nz ? regs_q[addr] : '0;
        assign rd_busy_o[i] = pend;
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned NRD    = 2;
    localparam int unsigned PEND_W = 2;
    localparam int unsigned AW     = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_dest;
    logic                iss_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic                pend_any;

    int n_pass  = 0;
    int n_total = 0;

    regfile_scoreboard #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NRD    (NRD),
        .PEND_W (PEND_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .iss_valid_i (iss_valid),
        .iss_dest_i  (iss_dest),
        .iss_ready_o (iss_ready),
        .wb_valid_i  (wb_valid),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .flush_i     (flush),
        .pend_any_o  (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic issue(input logic [AW-1:0] d);
        iss_valid = 1'b1;
        iss_dest  = d;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        iss_dest = 5'd5;
        wb_addr  = '0;
        wb_data  = '0;
        set_rd(5'd5, 5'd5);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;

        // Reset state
        chk("rst_data0", rd_data[63:0], 64'h0);
        chk("rst_data1", rd_data[127:64], 64'h0);
        chk("rst_busy", {62'h0, rd_busy}, 64'h0);
        chk("rst_iss_ready", {63'h0, iss_ready}, 64'h1);
        chk("rst_pend_any", {63'h0, pend_any}, 64'h0);

        // Issue r3, writeback two cycles later
        set_rd(5'd3, 5'd3);
        issue(5'd3);
        #2 chk("r3_busy_c0", {62'h0, rd_busy}, 64'h0);
        tick();
        idle();
        #2 chk("r3_busy_c1", {62'h0, rd_busy}, 64'h3);
        chk("r3_pend_c1", {63'h0, pend_any}, 64'h1);
        tick();
        wb(5'd3, 64'hDEAD);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("r3_data_c2", rd_data[63:0], 64'hDEAD);
        chk("r3_busy_c2", {62'h0, rd_busy}, 64'h0);
`else
        chk("r3_data_c2", rd_data[63:0], 64'h0);
        chk("r3_busy_c2", {62'h0, rd_busy}, 64'h3);
`endif
        tick();
        idle();
        #2 chk("r3_data_c3", rd_data[127:64], 64'hDEAD);
        chk("r3_busy_c3", {62'h0, rd_busy}, 64'h0);
        chk("r3_pend_c3", {63'h0, pend_any}, 64'h0);

        // Saturate r7
        set_rd(5'd7, 5'd7);
        issue(5'd7);
        #2 chk("r7_ready_0", {63'h0, iss_ready}, 64'h1);
        tick();
        tick();
        #2 chk("r7_ready_2", {63'h0, iss_ready}, 64'h1);
        tick();
        #2 chk("r7_ready_3", {63'h0, iss_ready}, 64'h0);
        tick();
        idle();
        #2 chk("r7_busy_after4", {62'h0, rd_busy}, 64'h3);
        chk("r7_ready_after4", {63'h0, iss_ready}, 64'h0);
        wb(5'd7, 64'h1);
        tick();
        wb(5'd7, 64'h2);
        #2 chk("r7_busy_wb2", {62'h0, rd_busy}, 64'h3);
        tick();
        wb(5'd7, 64'h3);
        #2 chk("r7_ready_cnt1", {63'h0, iss_ready}, 64'h1);
`ifdef REGFILE_BYPASS_EN
        chk("r7_busy_wb3", {62'h0, rd_busy}, 64'h0);
        chk("r7_data_wb3", rd_data[63:0], 64'h3);
`else
        chk("r7_busy_wb3", {62'h0, rd_busy}, 64'h3);
        chk("r7_data_wb3", rd_data[63:0], 64'h2);
`endif
        tick();
        idle();
        #2 chk("r7_busy_done", {62'h0, rd_busy}, 64'h0);
        chk("r7_data_done", rd_data[127:64], 64'h3);

        // Same-cycle issue and writeback on r4
        set_rd(5'd4, 5'd4);
        issue(5'd4);
        tick();
        issue(5'd4);
        wb(5'd4, 64'h44);
        #2 chk("r4_ready", {63'h0, iss_ready}, 64'h1);
        tick();
        idle();
        #2 chk("r4_busy", {62'h0, rd_busy}, 64'h3);
        chk("r4_data", rd_data[63:0], 64'h44);
        chk("r4_pend", {63'h0, pend_any}, 64'h1);
        wb(5'd4, 64'h45);
        tick();
        idle();
        #2 chk("r4_busy_clear", {62'h0, rd_busy}, 64'h0);
        chk("r4_pend_clear", {63'h0, pend_any}, 64'h0);

        // r0 writes and issues are ignored
        set_rd(5'd0, 5'd0);
        wb(5'd0, 64'hFFFF);
        issue(5'd0);
        #2 chk("r0_ready", {63'h0, iss_ready}, 64'h1);
        tick();
        idle();
        #2 chk("r0_data0", rd_data[63:0], 64'h0);
        chk("r0_data1", rd_data[127:64], 64'h0);
        chk("r0_busy", {62'h0, rd_busy}, 64'h0);
        chk("r0_pend", {63'h0, pend_any}, 64'h0);

        // Flush with same-cycle writeback and issue
        issue(5'd2);
        tick();
        tick();
        issue(5'd9);
        tick();
        idle();
        set_rd(5'd2, 5'd9);
        #2 chk("fl_busy_pre", {62'h0, rd_busy}, 64'h3);
        chk("fl_pend_pre", {63'h0, pend_any}, 64'h1);
        flush = 1'b1;
        wb(5'd9, 64'h55);
        issue(5'd2);
        tick();
        idle();
        #2 chk("fl_busy", {62'h0, rd_busy}, 64'h0);
        chk("fl_pend", {63'h0, pend_any}, 64'h0);
        chk("fl_r9_data", rd_data[127:64], 64'h55);
        chk("fl_r2_data", rd_data[63:0], 64'h0);

        // Asynchronous reset mid-cycle
        issue(5'd9);
        tick();
        idle();
        #2 chk("ar_busy_pre", {63'h0, rd_busy[1]}, 64'h1);
        rst_n = 1'b0;
        #1 chk("ar_busy", {62'h0, rd_busy}, 64'h0);
        chk("ar_data", rd_data[127:64], 64'h0);
        chk("ar_pend", {63'h0, pend_any}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
